// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, ALUOp, mux selects,
// and the opcode/funct3 values it decodes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_CMP   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS1   = 2'd1;
    localparam logic [1:0] SRCA_OLDPC = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic ADDR_PC       = 1'b0;
    localparam logic ADDR_ALUOUT   = 1'b1;
    localparam logic PCSRC_ALU     = 1'b0;
    localparam logic PCSRC_ALUOUT  = 1'b1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BLT = 3'b100;

    function automatic logic opcode_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control unit: one state register with combinational
// output and next-state decode; strobes depend on mem_ready in the same cycle.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       illegal,
    output logic [2:0] state
);

    localparam int              WAIT_W   = 16;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

    state_e            state_q, state_d;
    logic              illegal_q;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              req_c, we_c, irw_c, pcw_c, rw_c, ret_c;
    logic              wait_phase;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        wait_phase   = 1'b0;
        req_c        = 1'b0;
        we_c         = 1'b0;
        irw_c        = 1'b0;
        pcw_c        = 1'b0;
        rw_c         = 1'b0;
        ret_c        = 1'b0;
        mem_addr_sel = ADDR_PC;
        pc_src       = PCSRC_ALU;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RS2;
        alu_op       = ALUOP_ADD;
        wb_sel       = WB_ALUOUT;

        case (state_q)
            ST_FETCH: begin
                wait_phase = 1'b1;
                req_c      = 1'b1;
                alu_src_b  = SRCB_FOUR;
                if (mem_ready) begin
                    irw_c   = 1'b1;
                    pcw_c   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Branch/jump target is precomputed here from the old PC.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                state_d   = opcode_legal(opcode) ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_R: begin
                        alu_src_a = SRCA_RS1;
                        alu_op    = ALUOP_FUNCT;
                        state_d   = ST_WB;
                    end
                    OP_IMM, OP_LOAD, OP_STORE: begin
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_IMM;
                        state_d   = (opcode == OP_IMM) ? ST_WB : ST_MEM;
                    end
                    OP_BRANCH: begin
                        if (funct3 == F3_BEQ || funct3 == F3_BLT) begin
                            alu_src_a = SRCA_RS1;
                            alu_op    = ALUOP_CMP;
                            pcw_c     = (funct3 == F3_BEQ) ? alu_zero : alu_lt;
                            pc_src    = PCSRC_ALUOUT;
                            ret_c     = 1'b1;
                            state_d   = ST_FETCH;
                        end else begin
                            state_d = ST_TRAP;
                        end
                    end
                    OP_JAL: begin
                        pcw_c   = 1'b1;
                        pc_src  = PCSRC_ALUOUT;
                        rw_c    = 1'b1;
                        wb_sel  = WB_PC;
                        ret_c   = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                wait_phase   = 1'b1;
                req_c        = 1'b1;
                mem_addr_sel = ADDR_ALUOUT;
                we_c         = (opcode == OP_STORE);
                if (mem_ready) begin
                    ret_c   = (opcode == OP_STORE);
                    state_d = (opcode == OP_STORE) ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                rw_c    = 1'b1;
                wb_sel  = (opcode == OP_LOAD) ? WB_MDR : WB_ALUOUT;
                ret_c   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase

        // Wait counter overrides the next state once the limit is hit.
        if (wait_phase) begin
            if (mem_ready) begin
                wait_d = '0;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
                if (WAIT_LIMIT > 0 && wait_d == WAIT_MAX) state_d = ST_TRAP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_d == ST_TRAP) illegal_q <= 1'b1;
        end
    end

    assign mem_req   = req_c & rst_n;
    assign mem_we    = we_c & rst_n;
    assign ir_write  = irw_c & rst_n;
    assign pc_write  = pcw_c & rst_n;
    assign reg_write = rw_c & rst_n;
    assign retire    = ret_c & rst_n;
    assign illegal   = illegal_q;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into a
// list of phases and every cycle's outputs are compared with a phase model.
module tb_multicycle_ctrl;

    localparam int P_FETCH = 0, P_DEC = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_TRAP = 5;
    localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BLT = 5,
                   K_JAL = 6, K_BBAD = 7, K_ILL = 8;

    logic       clk, rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alu_zero, alu_lt, mem_ready;
    logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;
    logic       reg_write, retire, illegal;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire),
        .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] act_vec();
        return {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, retire, illegal};
    endfunction

    // Expected outputs for one cycle of a given phase of a given instruction.
    function automatic logic [19:0] model(input int ph, input int kind, input bit r,
                                          input bit z, input bit l);
        logic [2:0] st;
        logic mreq, mwe, asel, irw, pcw, pcs, rw, ret, ill;
        logic [1:0] a, b, op, wbs;
        st = 3'd0; {mreq, mwe, asel, irw, pcw, pcs, rw, ret, ill} = '0;
        a = 2'd0; b = 2'd0; op = 2'd0; wbs = 2'd0;
        case (ph)
            P_FETCH: begin mreq = 1; b = 2'd1; irw = r; pcw = r; end
            P_DEC:   begin st = 3'd1; a = 2'd2; b = 2'd2; end
            P_EXEC: begin
                st = 3'd2;
                case (kind)
                    K_R:               begin a = 2'd1; op = 2'b10; end
                    K_ADDI, K_LW, K_SW: begin a = 2'd1; b = 2'd2; end
                    K_BEQ: begin a = 2'd1; op = 2'b01; pcw = z; pcs = 1; ret = 1; end
                    K_BLT: begin a = 2'd1; op = 2'b01; pcw = l; pcs = 1; ret = 1; end
                    K_JAL: begin pcw = 1; pcs = 1; rw = 1; wbs = 2'd2; ret = 1; end
                    default: ;
                endcase
            end
            P_MEM: begin
                st = 3'd3; mreq = 1; asel = 1;
                mwe = (kind == K_SW);
                ret = (kind == K_SW) && r;
            end
            P_WB:   begin st = 3'd4; rw = 1; wbs = (kind == K_LW) ? 2'd1 : 2'd0; ret = 1; end
            P_TRAP: begin st = 3'd7; ill = 1; end
            default: ;
        endcase
        return {st, mreq, mwe, asel, irw, pcw, pcs, a, b, op, rw, wbs, ret, ill};
    endfunction

    function automatic int latency(input int kind);
        case (kind)
            K_BEQ, K_BLT, K_JAL: return 3;
            K_LW:                return 5;
            default:             return 4;
        endcase
    endfunction

    // Every task starts and ends just after a falling edge.
    task automatic do_reset();
        rst_n = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input int kind, input int fw, input int mw, input bit tie,
                             input int bz, input int stop, input string name);
        int ph_q[$];
        bit rd_q[$];
        int n, ret_at, waits;
        bit z, l, r;
        logic [19:0] exp_v, act_v;
        case (kind)
            K_R:    begin opcode = 7'b0110011; funct3 = 3'($urandom); end
            K_ADDI: begin opcode = 7'b0010011; funct3 = 3'b000; end
            K_LW:   begin opcode = 7'b0000011; funct3 = 3'b010; end
            K_SW:   begin opcode = 7'b0100011; funct3 = 3'b010; end
            K_BEQ:  begin opcode = 7'b1100011; funct3 = 3'b000; end
            K_BLT:  begin opcode = 7'b1100011; funct3 = 3'b100; end
            K_JAL:  begin opcode = 7'b1101111; funct3 = 3'($urandom); end
            K_BBAD: begin
                opcode = 7'b1100011;
                funct3 = 3'($urandom_range(1, 3));
                if (funct3 == 3'b011) funct3 = 3'b111;
            end
            default: begin opcode = 7'h7F; funct3 = 3'($urandom); end
        endcase
        for (int i = 0; i < fw; i++) begin ph_q.push_back(P_FETCH); rd_q.push_back(1'b0); end
        ph_q.push_back(P_FETCH); rd_q.push_back(1'b1);
        ph_q.push_back(P_DEC);   rd_q.push_back(1'b0);
        if (kind == K_ILL) begin
            ph_q.push_back(P_TRAP); rd_q.push_back(1'b0);
        end else begin
            ph_q.push_back(P_EXEC); rd_q.push_back(1'b0);
            if (kind == K_BBAD) begin ph_q.push_back(P_TRAP); rd_q.push_back(1'b0); end
            if (kind == K_LW || kind == K_SW) begin
                for (int i = 0; i < mw; i++) begin ph_q.push_back(P_MEM); rd_q.push_back(1'b0); end
                ph_q.push_back(P_MEM); rd_q.push_back(1'b1);
            end
            if (kind == K_R || kind == K_ADDI || kind == K_LW) begin
                ph_q.push_back(P_WB); rd_q.push_back(1'b0);
            end
        end
        n = (stop > 0) ? stop : ph_q.size();
        ret_at = 0;
        for (int i = 0; i < n; i++) begin
            z = (bz < 0) ? 1'($urandom_range(0, 1)) : bz[0];
            l = 1'($urandom_range(0, 1));
            if (ph_q[i] == P_FETCH || ph_q[i] == P_MEM) r = rd_q[i];
            else r = tie ? 1'b1 : 1'($urandom_range(0, 1));
            if (tie && ph_q[i] == P_FETCH) r = 1'b1;
            mem_ready = r; alu_zero = z; alu_lt = l;
            #1;
            exp_v = model(ph_q[i], kind, r, z, l);
            act_v = act_vec();
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d: outputs got %h expected %h", name, i, act_v, exp_v);
            end
            if (retire === 1'b1 && ret_at == 0) ret_at = i + 1;
            @(negedge clk);
        end
        if (stop == 0 && kind != K_BBAD && kind != K_ILL) begin
            waits = fw + ((kind == K_LW || kind == K_SW) ? mw : 0);
            n_tests++;
            if (ret_at != latency(kind) + waits) begin
                n_fail++;
                $display("FAIL %s latency: retire at cycle %0d expected %0d",
                         name, ret_at, latency(kind) + waits);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 7'b0110011; funct3 = 3'b000;
        alu_zero = 1'b1; alu_lt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if ({mem_req, mem_we, ir_write, pc_write, reg_write, retire} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_strobes: got %b expected 000000",
                         {mem_req, mem_we, ir_write, pc_write, reg_write, retire});
            end
            @(negedge clk);
        end
        rst_n = 1'b1; mem_ready = 1'b0;
        #1;
        n_tests++;
        if (act_vec() !== model(P_FETCH, K_R, 1'b0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", act_vec(),
                     model(P_FETCH, K_R, 1'b0, 1'b0, 1'b0));
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_trap_hold(input string name);
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'($urandom); alu_zero = 1'($urandom); alu_lt = 1'($urandom);
            opcode = 7'($urandom);
            #1;
            n_tests++;
            if (act_vec() !== model(P_TRAP, K_ILL, 1'b0, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL %s hold: got %h expected %h", name, act_vec(),
                         model(P_TRAP, K_ILL, 1'b0, 1'b0, 1'b0));
            end
            @(negedge clk);
        end
        rst_n = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (state !== 3'd0 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL %s clear: state %0d illegal %b expected 0 0", name, state, illegal);
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_wait_limit();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b0;
            #1;
            n_tests++;
            if (act_vec() !== model(P_FETCH, K_R, 1'b0, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL wait_limit cycle %0d: got %h expected %h", i, act_vec(),
                         model(P_FETCH, K_R, 1'b0, 1'b0, 1'b0));
            end
            @(negedge clk);
        end
        test_trap_hold("wait_limit_trap");
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        run_instr(K_SW, 0, 3, 1'b0, -1, 4, "sw_mid_mem");
        mem_ready = 1'b0;
        #1;
        n_tests++;
        if ({mem_req, mem_we} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_mem_pending: req/we got %b expected 11", {mem_req, mem_we});
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({mem_req, mem_we, ir_write, pc_write, reg_write, retire} !== 6'b0) begin
            n_fail++;
            $display("FAIL mid_mem_abort: strobes got %b expected 000000",
                     {mem_req, mem_we, ir_write, pc_write, reg_write, retire});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (state !== 3'd0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_mem_fetch: state %0d we %b expected 0 0", state, mem_we);
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_random();
        int k;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 6);
            run_instr(k, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, -1, 0, "random");
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; alu_lt = 1'b0;
        opcode = 7'd0; funct3 = 3'd0;
        @(negedge clk);
        test_reset();
        run_instr(K_R, 0, 0, 1'b1, -1, 0, "add_ready_tied");
        run_instr(K_LW, 0, 2, 1'b0, -1, 0, "lw_wait2");
        run_instr(K_BEQ, 1, 0, 1'b0, 1, 0, "beq_taken");
        run_instr(K_BEQ, 0, 0, 1'b0, 0, 0, "beq_not_taken");
        run_instr(K_BLT, 2, 0, 1'b0, -1, 0, "blt");
        run_instr(K_JAL, 0, 0, 1'b0, -1, 0, "jal");
        run_instr(K_SW, 3, 3, 1'b0, -1, 0, "sw_waits");
        run_instr(K_ADDI, 0, 0, 1'b0, -1, 0, "addi");
        run_instr(K_ILL, 0, 0, 1'b0, -1, 0, "illegal_op");
        test_trap_hold("illegal_op_trap");
        run_instr(K_BBAD, 0, 0, 1'b0, -1, 0, "bad_branch");
        test_trap_hold("bad_branch_trap");
        test_wait_limit();
        test_reset_mid_mem();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_LIMIT, default 0: maximum mem_ready wait cycles per access; 0 means unlimited.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- opcode  in  7  opcode field of the instruction register.
- funct3  in  3  funct3 field of the instruction register.
- alu_zero  in  1  ALU result == 0.
- alu_lt  in  1  ALU signed less-than flag.
- mem_ready  in  1  memory completes the current request.
- mem_req  out  1  memory request.
- mem_we  out  1  write request.
- mem_addr_sel  out  1  address source: 0=PC, 1=ALUOut.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  load PC.
- pc_src  out  1  PC source: 0=ALU result, 1=ALUOut.
- alu_src_a  out  2  A input: 0=PC, 1=rs1, 2=oldPC.
- alu_src_b  out  2  B input: 0=rs2, 1=const 4, 2=imm.
- alu_op  out  2  ALUOp: 00=add, 01=compare, 10=funct-decoded.
- reg_write  out  1  register file write.
- wb_sel  out  2  write-back source: 0=ALUOut, 1=MDR, 2=PC.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  sticky trap flag.
- state  out  3  current state.

Function
REQ-003 The state encoding SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
REQ-004 In FETCH, the block SHALL hold mem_req=1, mem_addr_sel=0, mem_we=0, alu_src_a=0, alu_src_b=1 and alu_op=00.
- On a cycle with mem_ready=1, it SHALL assert ir_write=1, pc_write=1 and pc_src=0, then go to DECODE.
- Otherwise it SHALL stay in FETCH.
REQ-005 In DECODE, the block SHALL drive alu_src_a=2, alu_src_b=2, alu_op=00 (branch/jump target into ALUOut), then go to EXEC.
- If opcode is not R, B, J, addi, lw or sw, it SHALL go to TRAP instead.
REQ-006 EXEC behaviour per instruction class SHALL be:
- R: a=1, b=0, op=10, then WB.
- addi, lw, sw: a=1, b=2, op=00; addi goes to WB, lw and sw go to MEM.
- B: a=1, b=0, op=01; pc_write=alu_zero for BEQ, alu_lt for BLT; pc_src=1; retire=1; then FETCH.
- jal: pc_write=1, pc_src=1, reg_write=1, wb_sel=2, retire=1, then FETCH.
REQ-007 A B-format instruction with a funct3 other than BEQ or BLT SHALL go to TRAP from EXEC with no PC write.
REQ-008 In MEM, the block SHALL hold mem_req=1, mem_addr_sel=1 and mem_we=(sw).
- On mem_ready=1: lw goes to WB; sw asserts retire=1 and goes to FETCH.
- Otherwise it SHALL stay in MEM.
REQ-009 In WB, the block SHALL assert reg_write=1 (wb_sel=1 for lw, 0 otherwise) and retire=1, then go to FETCH.
REQ-010 mem_req, mem_we and mem_addr_sel SHALL stay stable from request until the cycle mem_ready=1 is sampled; same-cycle ready (zero wait) SHALL be legal.
REQ-011 mem_ready SHALL be ignored outside FETCH and MEM.
REQ-012 Latency excluding wait cycles SHALL be: B and jal 3, R/addi/sw 4, lw 5 cycles.
REQ-013 A wait counter SHALL increment each FETCH or MEM cycle without mem_ready and clear on completion.
- When WAIT_LIMIT>0 and the count reaches WAIT_LIMIT, the next state SHALL be TRAP.
REQ-014 TRAP SHALL hold illegal=1 with all strobes at 0 until reset.
REQ-015 Outputs not named for a state SHALL be 0.

Reset
REQ-016 On a clock edge with rst_n=0, the block SHALL set state to FETCH and clear illegal and the wait counter.
REQ-017 While rst_n=0, mem_req, mem_we, ir_write, pc_write, reg_write and retire SHALL be forced to 0.
REQ-018 Reset in any state, including mid-MEM with a pending request, SHALL abort that state with no write strobes asserted.

Structure
REQ-019 The following SHALL live in shared const.v: state encodings, ALUOp encodings, mux-select encodings, and the opcode/funct3 defines already used by ALU control.
REQ-020 The block SHALL be implemented as a single module, one state register plus combinational output/next-state decode, with no sub-module.

Verification
REQ-021 The bench SHALL cover these scenarios:
- add, mem_ready tied 1 -> states 0,1,2,4; reg_write and retire in cycle 4; alu_op=10 in EXEC.
- lw with 2 wait cycles in MEM -> mem_req=1, mem_addr_sel=1 for 3 cycles; wb_sel=1 in WB; 7 cycles total.
- beq with alu_zero=1 then alu_zero=0 -> pc_write=1, pc_src=1 in EXEC; then pc_write=0; both retire.
- opcode 0x7F -> state 7 after DECODE; illegal=1 until rst_n=0; then FETCH.
- WAIT_LIMIT=4, mem_ready held 0 in FETCH -> TRAP after 4 wait cycles.
- rst_n=0 during sw MEM -> mem_req and mem_we drop the same cycle; FETCH next edge.
